// File: rtl/fir_delay_line.sv
`timescale 1ns/1ps
// Multi-channel circular sample history on a single-port-style block RAM.
// Each accepted sample is written to its channel ring, then the last TAPS samples stream out newest first.
module fir_delay_line #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 1,
  parameter int TAP_W  = 8,
  parameter int TAPS   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [TAP_W-1:0]  out_idx,
  output logic              out_first,
  output logic              out_last
);

  localparam int AW    = CH_W + TAP_W;
  localparam int DEPTH = 2 ** AW;
  localparam int NCH   = 2 ** CH_W;
  localparam logic [TAP_W-1:0] LAST_K = TAP_W'(TAPS - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t              state_q;
  logic [AW-1:0]       sweep_q;
  logic [TAP_W-1:0]    head_q [NCH];
  logic [CH_W-1:0]     ch_q;
  logic [DATA_W-1:0]   data_q;
  logic [TAP_W-1:0]    base_q;
  logic [TAP_W-1:0]    k_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [TAP_W-1:0]    out_idx_q;
  logic                out_first_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en_d;
  logic [AW-1:0]       wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic                rd_en_d;
  logic [AW-1:0]       rd_addr_d;

  // RAM port control: clr suppresses both the pending write and the pending read.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = sweep_q;
    wr_data_d = '0;
    rd_en_d   = 1'b0;
    rd_addr_d = {ch_q, base_q - k_q};
    if (!clr) begin
      case (state_q)
        S_CLEAR: wr_en_d = 1'b1;
        S_WRITE: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {ch_q, head_q[ch_q]};
          wr_data_d = data_q;
        end
        S_READ:  rd_en_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_addr_d] <= wr_data_d;
  end

  // Read register doubles as the output data register, so it only loads on a tap issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_d) rd_data_q <= mem_q[rd_addr_d];
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) data_q <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      sweep_q     <= '0;
      for (int i = 0; i < NCH; i++) head_q[i] <= '0;
      ch_q        <= '0;
      base_q      <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (clr) begin
      state_q     <= S_CLEAR;
      sweep_q     <= '0;
      for (int i = 0; i < NCH; i++) head_q[i] <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          for (int i = 0; i < NCH; i++) head_q[i] <= '0;
          if (sweep_q == '1) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            ch_q       <= in_ch;
            state_q    <= S_WRITE;
            in_ready_q <= 1'b0;
          end
        end
        S_WRITE: begin
          head_q[ch_q] <= head_q[ch_q] + 1'b1;
          base_q       <= head_q[ch_q];
          k_q          <= '0;
          state_q      <= S_READ;
        end
        // Tap issue: output fields are registered alongside the RAM read.
        S_READ: begin
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          out_idx_q   <= k_q;
          out_first_q <= (k_q == '0);
          out_last_q  <= (k_q == LAST_K);
          k_q         <= k_q + 1'b1;
          if (k_q == LAST_K) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = rd_data_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fir_delay_line.sv
`timescale 1ns/1ps
// Randomized bench for fir_delay_line against a per-channel write-history model.
module tb_fir_delay_line;
  localparam int DATA_W = 24;
  localparam int CH_W   = 1;
  localparam int TAP_W  = 8;
  localparam int TAPS   = 128;
  localparam int DEPTH  = 512;
  localparam int HMAX   = 4096;

  logic              clk = 1'b0;
  logic              rst, clr, in_valid, in_ready;
  logic [CH_W-1:0]   in_ch, out_ch;
  logic [DATA_W-1:0] in_data, out_data;
  logic              out_valid, out_first, out_last;
  logic [TAP_W-1:0]  out_idx;

  int total = 0;
  int bad   = 0;

  // Model: every sample ever written per channel since the last clear; tap k is the k-th newest.
  logic [DATA_W-1:0] hist [2][HMAX];
  int                cnt  [2];

  fir_delay_line #(.DATA_W(DATA_W), .CH_W(CH_W), .TAP_W(TAP_W), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_tap(input int ch, input int k);
    if (k < cnt[ch]) return hist[ch][cnt[ch]-1-k];
    return '0;
  endfunction

  task automatic model_clear();
    cnt[0] = 0;
    cnt[1] = 0;
  endtask

  task automatic model_push(input int ch, input logic [DATA_W-1:0] d);
    hist[ch][cnt[ch]] = d;
    cnt[ch]++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic chk_tap(input int ch, input int k);
    chk("data",  32'(out_data),  32'(model_tap(ch, k)));
    chk("idx",   32'(out_idx),   32'(k));
    chk("ch",    32'(out_ch),    32'(ch));
    chk("first", 32'(out_first), 32'(k == 0));
    chk("last",  32'(out_last),  32'(k == TAPS-1));
  endtask

  // One sample plus its full stream, checked cycle by cycle; noise drives ignored in_valid pulses.
  task automatic send(input int ch, input logic [DATA_W-1:0] d, input bit noise);
    wait_ready();
    in_ch    = CH_W'(ch);
    in_data  = d;
    in_valid = 1'b1;
    model_push(ch, d);
    for (int j = 1; j <= TAPS+3; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (noise && j <= TAPS) begin
        in_valid = 1'($urandom_range(0, 1));
        in_ch    = CH_W'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
      end
      chk("ready", 32'(in_ready), 32'(j == TAPS+3));
      chk("valid", 32'(out_valid), 32'(j >= 3 && j <= TAPS+2));
      if (j >= 3 && j <= TAPS+2) chk_tap(ch, j-3);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(in_ready),  32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_ch"},    32'(out_ch),    32'd0);
    chk({tag, "_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_first"}, 32'(out_first), 32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  // Called at the negedge where the clear sweep begins; pulses in_valid during the sweep when asked.
  task automatic chk_sweep(input string tag, input bit pulses);
    for (int p = 0; p <= DEPTH; p++) begin
      chk({tag, "_ready"}, 32'(in_ready), 32'(p == DEPTH));
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      in_valid = pulses && (p < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (p < DEPTH) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] hold;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    chk_sweep("init", 1'b0);

    // Impulse on channel 0: fifth stream shows the 1 at tap 4.
    send(0, 24'd1, 1'b0);
    for (int i = 0; i < 4; i++) send(0, 24'd0, 1'b0);

    // Channel isolation with interleaved writes.
    for (int i = 0; i < 4; i++) begin
      send(0, 24'h000001 + 24'(i), 1'b1);
      send(1, 24'h800000 + 24'(i), 1'b1);
    end

    // Ring wrap on channel 1.
    for (int n = 0; n < 300; n++) send(1, 24'(n), bit'(n % 2));

    // Random traffic with idle gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(int'($urandom_range(0, 1)), DATA_W'($urandom), 1'b1);
    end

    // clr at the third output of a stream.
    wait_ready();
    in_ch = 1'b0; in_data = 24'h123456; in_valid = 1'b1;
    model_push(0, 24'h123456);
    hold = '0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (j >= 3) chk_tap(0, j-3);
    end
    hold = model_tap(0, 2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_hold",  32'(out_data),  32'(hold));
    model_clear();
    chk_sweep("clr", 1'b0);
    send(0, 24'd7, 1'b0);
    send(1, 24'd9, 1'b0);

    // Asynchronous reset in the middle of a channel-1 stream.
    wait_ready();
    in_ch = 1'b1; in_data = 24'h00abcd; in_valid = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk_sweep("rst", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
    end
    send(1, 24'habcdef, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_delay_line.md
# fir_delay_line

Multi-channel circular sample history for the FIR datapath, built on a single-clock block RAM. For each accepted input sample it stores the sample in its channel's ring and streams the last TAPS samples of that channel, newest first, to the MAC stage with tap index and first/last markers. After reset or on request it zeroes the whole memory by hardware sweep, so it never depends on simulation-only initialisation.

## Interface

- DATA_W, 24, sample width
- CH_W, 1, channel-select width; channels = 2**CH_W
- TAP_W, 8, per-channel ring address width; ring depth = 2**TAP_W
- TAPS, 128, taps streamed per sample; legal range 1..2**TAP_W

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous request to zero all history and pointers
- in_valid  in  1  input sample present
- in_ready  out  1  block idle and accepting
- in_ch  in  CH_W  channel of input sample
- in_data  in  DATA_W  input sample
- out_valid  out  1  out_* fields valid this cycle (no backpressure)
- out_data  out  DATA_W  history sample
- out_ch  out  CH_W  channel being streamed
- out_idx  out  TAP_W  tap index k (0 = newest)
- out_first  out  1  high with k = 0
- out_last  out  1  high with k = TAPS-1

## Operation

- Memory: 2**(CH_W+TAP_W) words of DATA_W, block RAM, address {ch, ptr}; 1-cycle registered read.
- Per-channel head pointer head[ch] (TAP_W bits) points to the next write slot; arithmetic modulo 2**TAP_W.
- States: CLEAR, IDLE, WRITE, READ, DRAIN.
- CLEAR: write 0 to address sweep counter 0..2**(CH_W+TAP_W)-1, one word per cycle; all head[] = 0; in_ready = 0; after last address -> IDLE.
- IDLE: in_ready = 1; on in_valid capture in_ch/in_data -> WRITE. in_valid while in_ready = 0 is ignored (not queued).
- WRITE: mem[{ch, head[ch]}] <= data; head[ch] <= head[ch]+1; k <= 0 -> READ.
- READ: read address {ch, head_old - k}, where head_old is the pre-increment pointer (the just-written slot); k increments each cycle; when k = TAPS-1 issued -> DRAIN.
- DRAIN: presents final tap; -> IDLE.
- Output stage: registered one cycle after each READ issue; out_idx = k of that issue; out_first = (k==0); out_last = (k==TAPS-1); out_ch = captured ch. out_valid = 0 in all other cycles; out_data/out_idx/out_ch hold last value when out_valid = 0.
- Samples older than written history read as 0 (memory cleared).
- Channels are fully isolated: writes to one channel never alter another channel's ring or head.
- clr: sampled in every state; highest priority after rst; aborts any WRITE/READ/DRAIN (abort in WRITE means the write does not occur); out_valid = 0 from the next cycle; -> CLEAR.
- rst: immediately forces state CLEAR, sweep counter 0, head[] = 0, outputs to reset values.

## Timing

- Reset values: in_ready 0, out_valid 0, out_data 0, out_ch 0, out_idx 0, out_first 0, out_last 0.
- Clear duration: 2**(CH_W+TAP_W) cycles (512 at defaults); in_ready rises the cycle after the last clear write.
- Handshake at cycle 0 (in_valid & in_ready): in_ready falls in cycle 1 (WRITE).
- READ issues cycles 2..TAPS+1; out_valid cycles 3..TAPS+2 (out_first at 3, out_last at TAPS+2).
- in_ready high again cycle TAPS+3; sustained throughput one sample per TAPS+3 cycles.
- TAPS = 1: out_first and out_last both high in the single output cycle.
- Wrap-around: head_old - k below 0 wraps to top of ring; head wraps 2**TAP_W-1 -> 0.

## Test plan

- Reset release, no stimulus -> in_ready stays 0 for 512 cycles, then 1; out_valid never asserts.
- Ch0 impulse: write 1, then 0 x4, each with full stream -> fifth stream shows out_data = 1 only at out_idx = 4, all other taps 0; out_first/out_last at idx 0/127.
- Channel isolation: ch0 writes 0x000001.., ch1 writes 0x800000.. interleaved -> each stream contains only its own channel's values, out_ch correct.
- Wrap: 300 writes to ch1 with data = n -> stream after write n=299 gives out_data = 299-k for k = 0..127; head crossed 255 -> 0.
- clr asserted at 3rd out_valid of a stream -> out_valid 0 next cycle, 512-cycle CLEAR, subsequent stream after a single write of 7 shows 7 then 127 zeros.
- rst asserted mid-READ -> all outputs zero immediately, in_ready 0; in_valid pulses during CLEAR ignored (no stream produced).
